// File: rtl/ps2_keyboard_wb.sv
// PS/2 keyboard receiver with a scancode FIFO, exposed as a Wishbone slave.
// DATA register pops the FIFO head; STATUS reports count and sticky error flags.
module ps2_keyboard_wb #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PS2C,
  input  logic        PS2D,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        kbd_int
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]      TLIM     = TW'(TIMEOUT - 1);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rxState_t;

  rxState_t r_state, w_nextState;

  logic r_c1, r_c2, r_cPrev, r_d1, r_d2;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic          r_parOk;
  logic [TW-1:0] r_idleCnt;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wrPtr, r_rdPtr;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf, r_perr, r_ferr;

  logic w_fall, w_timeout, w_push, w_setPerr, w_setFerr;
  logic w_accept, w_pop, w_flush, w_full, w_doPush, w_setOvf;
  logic w_clrOvf, w_clrPerr, w_clrFerr;
  logic w_unused;

  assign w_unused = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:4]};

  // Synchronised pins; pins idle high, so reset to 1 to avoid a phantom edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c1    <= 1'b1;
      r_c2    <= 1'b1;
      r_cPrev <= 1'b1;
      r_d1    <= 1'b1;
      r_d2    <= 1'b1;
    end else begin
      r_c1    <= PS2C;
      r_c2    <= r_c1;
      r_cPrev <= r_c2;
      r_d1    <= PS2D;
      r_d2    <= r_d1;
    end
  end

  assign w_fall    = r_cPrev & ~r_c2;
  assign w_timeout = (r_state != ST_IDLE) && (r_idleCnt == TLIM) && !w_fall;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    w_setPerr   = 1'b0;
    w_setFerr   = 1'b0;
    if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!r_d2) w_nextState = ST_DATA;
        ST_DATA:   if (r_bitCnt == 3'd7) w_nextState = ST_PARITY;
        ST_PARITY: w_nextState = ST_STOP;
        ST_STOP: begin
          w_nextState = ST_IDLE;
          if (r_d2) begin
            w_push    = r_parOk;
            w_setPerr = !r_parOk;
          end else begin
            w_setFerr = 1'b1;
          end
        end
        default:   w_nextState = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_nextState = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_parOk   <= 1'b0;
      r_idleCnt <= '0;
    end else begin
      if (w_fall || r_state == ST_IDLE || w_timeout) r_idleCnt <= '0;
      else                                           r_idleCnt <= r_idleCnt + 1'b1;
      if (w_fall) begin
        case (r_state)
          ST_IDLE:   r_bitCnt <= '0;
          ST_DATA: begin
            r_shift  <= {r_d2, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
          end
          ST_PARITY: r_parOk <= ^{r_shift, r_d2};
          default:   ;
        endcase
      end
    end
  end

  assign w_accept  = STB && !ACK;
  assign w_pop     = w_accept && !WE && !ADDR[2] && (r_count != '0);
  assign w_flush   = w_accept && WE && ADDR[2] && DAT_I[3];
  assign w_clrOvf  = w_accept && WE && ADDR[2] && DAT_I[0];
  assign w_clrPerr = w_accept && WE && ADDR[2] && DAT_I[1];
  assign w_clrFerr = w_accept && WE && ADDR[2] && DAT_I[2];
  assign w_full    = (r_count == FULL_CNT);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign w_doPush  = w_push && (!w_full || w_pop) && !w_flush;
  assign w_setOvf  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
      if (w_doPush && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_doPush && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovf  <= w_setOvf  | (r_ovf  & ~w_clrOvf);
      r_perr <= w_setPerr | (r_perr & ~w_clrPerr);
      r_ferr <= w_setFerr | (r_ferr & ~w_clrFerr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ACK     <= 1'b0;
      DAT_O   <= '0;
      kbd_int <= 1'b0;
    end else begin
      ACK     <= w_accept;
      kbd_int <= (r_count != '0);
      DAT_O   <= '0;
      if (w_accept && !WE) begin
        if (ADDR[2])    DAT_O <= {16'b0, 8'(r_count), 5'b0, r_ferr, r_perr, r_ovf};
        else if (w_pop) DAT_O <= {1'b1, 23'b0, r_mem[r_rdPtr]};
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_wb.sv
// Self-checking bench for ps2_keyboard_wb: directed scenarios plus random traffic
// compared against a queue-based model of the FIFO and sticky flags.
module tb_ps2_keyboard_wb;

  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        reset, PS2C, PS2D, STB, WE;
  logic [31:0] ADDR, DAT_I, DAT_O;
  logic        ACK, kbd_int;

  int nChecks = 0;
  int nFails  = 0;

  byte unsigned mq[$];
  bit mOvf, mPerr, mFerr;

  ps2_keyboard_wb #(.FIFO_AW(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .PS2C(PS2C), .PS2D(PS2D),
    .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK(ACK), .kbd_int(kbd_int)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] expStatus();
    return {16'b0, 8'(mq.size()), 5'b0, mFerr, mPerr, mOvf};
  endfunction

  function automatic void modelFrame(input byte unsigned d, input bit parBad, input bit stopBad);
    if (stopBad)              mFerr = 1'b1;
    else if (parBad)          mPerr = 1'b1;
    else if (mq.size() == 8)  mOvf  = 1'b1;
    else                      mq.push_back(d);
  endfunction

  function automatic void modelReset();
    mq.delete();
    mOvf = 0; mPerr = 0; mFerr = 0;
  endfunction

  // One bus cycle; checks one-cycle ACK latency and that DAT_O/ACK fall afterwards
  task automatic busAccess(input bit we, input bit addr2, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    int lat;
    STB   = 1'b1;
    WE    = we;
    ADDR  = ($urandom() & 32'hFFFF_FFFB) | (addr2 ? 32'h4 : 32'h0);
    DAT_I = wdata;
    lat   = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ACK && lat < 10);
    rdata = DAT_O;
    checkOutput("ackLatency", lat, 1);
    STB = 1'b0; WE = 1'b0; DAT_I = '0;
    @(negedge clk);
    checkOutput("ackOneCycle", {31'b0, ACK}, 32'd0);
    checkOutput("datoIdle", DAT_O, 32'd0);
  endtask

  task automatic readData(input string tag);
    logic [31:0] exp, got;
    exp = (mq.size() != 0) ? {1'b1, 23'b0, mq.pop_front()} : 32'd0;
    busAccess(1'b0, 1'b0, 32'd0, got);
    checkOutput(tag, got, exp);
  endtask

  task automatic readStatus(input string tag);
    logic [31:0] exp, got;
    exp = expStatus();
    busAccess(1'b0, 1'b1, 32'd0, got);
    checkOutput(tag, got, exp);
  endtask

  task automatic writeStatus(input logic [3:0] b);
    logic [31:0] got;
    busAccess(1'b1, 1'b1, {$urandom_range(0, 65535), 12'h0, b}, got);
    if (b[0]) mOvf  = 0;
    if (b[1]) mPerr = 0;
    if (b[2]) mFerr = 0;
    if (b[3]) mq.delete();
  endtask

  task automatic checkInt();
    waitCycles(2);
    checkOutput("kbdInt", {31'b0, kbd_int}, (mq.size() != 0) ? 32'd1 : 32'd0);
  endtask

  // Send the first nBits of a PS/2 frame; optionally pop DATA in the push cycle
  task automatic applyStimulus(input byte unsigned d, input bit parBad, input bit stopBad,
                               input int nBits, input bit popAtStop);
    logic [10:0] bits;
    logic [31:0] popExp;
    bits = {~stopBad, (~^d) ^ parBad, d, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      PS2D = bits[i];
      waitCycles(HALF);
      PS2C = 1'b0;
      if (popAtStop && i == 10) begin
        popExp = (mq.size() != 0) ? {1'b1, 23'b0, mq.pop_front()} : 32'd0;
        waitCycles(2);
        STB = 1'b1; WE = 1'b0; ADDR = 32'h0;
        waitCycles(1);
        checkOutput("popAckAtPush", {31'b0, ACK}, 32'd1);
        checkOutput("popAtPush", DAT_O, popExp);
        STB = 1'b0;
        waitCycles(HALF - 3);
      end else begin
        waitCycles(HALF);
      end
      PS2C = 1'b1;
    end
    waitCycles(HALF);
    PS2D = 1'b1;
    if (nBits == 11) modelFrame(d, parBad, stopBad);
  endtask

  initial begin
    logic [31:0] dummy;
    int r;
    reset = 1'b1; PS2C = 1'b1; PS2D = 1'b1;
    STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
    modelReset();
    waitCycles(3);
    checkOutput("resetAck", {31'b0, ACK}, 32'd0);
    checkOutput("resetDatO", DAT_O, 32'd0);
    checkOutput("resetInt", {31'b0, kbd_int}, 32'd0);
    reset = 1'b0;
    waitCycles(2);
    readStatus("resetStatus");

    $display("[TB] good frame 0x1C");
    applyStimulus(8'h1C, 1'b0, 1'b0, 11, 1'b0);
    checkInt();
    readData("data1C");
    readStatus("statusAfter1C");
    checkInt();

    $display("[TB] parity error");
    applyStimulus(8'h1C, 1'b1, 1'b0, 11, 1'b0);
    readStatus("statusPerr");
    writeStatus(4'h2);
    readStatus("statusPerrCleared");

    $display("[TB] framing error");
    applyStimulus(8'h33, 1'b0, 1'b1, 11, 1'b0);
    readStatus("statusFerr");
    writeStatus(4'h4);

    $display("[TB] overflow");
    for (int i = 1; i <= 9; i++) applyStimulus(byte'(i), 1'b0, 1'b0, 11, 1'b0);
    readStatus("statusOvf");
    checkInt();
    for (int i = 0; i < 9; i++) readData("drainOvf");
    checkInt();
    writeStatus(4'h1);
    readStatus("statusOvfCleared");

    $display("[TB] timeout");
    applyStimulus(8'($urandom), 1'b0, 1'b0, 5, 1'b0);
    waitCycles(TMO + 50);
    applyStimulus(8'h5A, 1'b0, 1'b0, 11, 1'b0);
    readStatus("statusAfterTimeout");
    readData("data5A");
    readData("emptyAfter5A");

    $display("[TB] pop coinciding with push on full fifo");
    for (int i = 0; i < 8; i++) applyStimulus(8'($urandom), 1'b0, 1'b0, 11, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0, 11, 1'b1);
    readStatus("statusFullPopPush");
    for (int i = 0; i < 8; i++) readData("drainFull");
    readData("emptyAfterDrain");

    $display("[TB] flush");
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 1'b0, 1'b0, 11, 1'b0);
    writeStatus(4'h8);
    readStatus("statusFlushed");
    checkInt();

    $display("[TB] reset mid-frame");
    applyStimulus(8'h77, 1'b0, 1'b0, 11, 1'b0);
    applyStimulus(8'h29, 1'b0, 1'b0, 6, 1'b0);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("midResetAck", {31'b0, ACK}, 32'd0);
    checkOutput("midResetDatO", DAT_O, 32'd0);
    checkOutput("midResetInt", {31'b0, kbd_int}, 32'd0);
    waitCycles(2);
    reset = 1'b0;
    modelReset();
    waitCycles(5);
    applyStimulus(8'h29, 1'b0, 1'b0, 11, 1'b0);
    readData("data29");
    readData("emptyAfter29");

    $display("[TB] random traffic");
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: applyStimulus(8'($urandom), $urandom_range(0, 7) == 0,
                                  $urandom_range(0, 7) == 0, 11, 1'b0);
        4, 5: readData("rndData");
        6:    readStatus("rndStatus");
        7:    writeStatus(4'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 4'h8 : 4'h0));
        8:    checkInt();
        default: begin
          busAccess(1'b1, 1'b0, $urandom(), dummy);
          readStatus("rndStatusAfterDataWrite");
        end
      endcase
    end
    readStatus("finalStatus");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
